// File: rtl/multi_delay_line.sv
// Multi-channel gated delay line with run-time selectable depth (0..max_len)
// and a fill tracker that flags when the tap holds fully delayed data.
module multi_delay_line #(
    parameter int dw      = 16,
    parameter int nch     = 2,
    parameter int max_len = 4,
    parameter int aw      = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                gate,
    input  logic [aw-1:0]       delay,
    input  logic [nch*dw-1:0]   din,
    output logic [nch*dw-1:0]   dout,
    output logic                valid,
    output logic                clamped
);

    localparam int              W     = nch * dw;
    localparam logic [aw-1:0]   MAX_D = aw'(max_len);

    function automatic logic [aw-1:0] sat_delay(input logic [aw-1:0] d);
        return (d > MAX_D) ? MAX_D : d;
    endfunction

    // All channels share one tap, so each stage holds the full packed word.
    logic [W-1:0]  stage_q [1:max_len];
    logic [W-1:0]  stage_d [1:max_len];
    logic [aw-1:0] delay_r_q, delay_r_d;
    logic [aw-1:0] fill_q, fill_d;
    logic          clamped_q, clamped_d;
    logic          change;

    always_comb begin
        stage_d = stage_q;
        if (gate) begin
            stage_d[1] = din;
            for (int i = 2; i <= max_len; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    // A change cycle restarts the fill count; the sample shifted in that
    // same cycle already counts toward the new delay.
    always_comb begin
        delay_r_d = sat_delay(delay);
        clamped_d = (delay > MAX_D);
        change    = (delay_r_d != delay_r_q);
        fill_d    = fill_q;
        if (change) begin
            fill_d = gate ? aw'(1) : '0;
        end else if (gate && (fill_q < MAX_D)) begin
            fill_d = fill_q + aw'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i <= max_len; i++) begin
                stage_q[i] <= '0;
            end
            delay_r_q <= '0;
            fill_q    <= '0;
            clamped_q <= 1'b0;
        end else begin
            stage_q   <= stage_d;
            delay_r_q <= delay_r_d;
            fill_q    <= fill_d;
            clamped_q <= clamped_d;
        end
    end

    // Delay 0 is a zero-latency passthrough of the live input.
    always_comb begin
        dout = din;
        for (int i = 1; i <= max_len; i++) begin
            if (delay_r_q == aw'(i)) begin
                dout = stage_q[i];
            end
        end
    end

    assign valid   = (fill_q >= delay_r_q);
    assign clamped = clamped_q;

endmodule

// File: tb/tb_multi_delay_line.sv
// Directed bench for multi_delay_line: a queue-based scoreboard fed by a
// history model, plus fixed expectations at the key points of each scenario.
module tb_multi_delay_line;

    localparam int DW   = 16;
    localparam int NCH  = 2;
    localparam int MAXL = 4;
    localparam int AW   = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 gate;
    logic [AW-1:0]        delay;
    logic [NCH*DW-1:0]    din;
    logic [NCH*DW-1:0]    dout;
    logic                 valid;
    logic                 clamped;

    multi_delay_line #(.dw(DW), .nch(NCH), .max_len(MAXL), .aw(AW)) dut (
        .clk(clk), .rst(rst), .gate(gate), .delay(delay),
        .din(din), .dout(dout), .valid(valid), .clamped(clamped)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] dout;
        logic        valid;
        logic        clamped;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] hist[$];
    int          m_dr;
    int          m_fill;
    logic        m_cl;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        if (m_dr == 0)               e.dout = din;
        else if (hist.size() >= m_dr) e.dout = hist[m_dr-1];
        else                         e.dout = '0;
        e.valid   = (m_fill >= m_dr);
        e.clamped = m_cl;
        return e;
    endfunction

    function automatic void model_reset();
        hist.delete();
        m_dr   = 0;
        m_fill = 0;
        m_cl   = 1'b0;
    endfunction

    function automatic void model_edge();
        int sat;
        sat = (int'(delay) > MAXL) ? MAXL : int'(delay);
        if (gate) begin
            hist.push_front(din);
            if (hist.size() > MAXL) void'(hist.pop_back());
        end
        if (sat != m_dr)                   m_fill = gate ? 1 : 0;
        else if (gate && (m_fill < MAXL))  m_fill++;
        m_dr = sat;
        m_cl = (int'(delay) > MAXL);
    endfunction

    task automatic cyc(input logic r, input logic g, input logic [AW-1:0] d, input logic [31:0] x);
        exp_t e;
        @(negedge clk);
        rst = r; gate = g; delay = d; din = x;
        if (r) model_reset();
        sb.push_back(model_out());
        #1;
        e = sb.pop_front();
        check("sb_dout", dout, e.dout);
        check("sb_valid", 32'(valid), 32'(e.valid));
        check("sb_clamped", 32'(clamped), 32'(e.clamped));
        @(posedge clk);
        if (!r) model_edge();
    endtask

    initial begin
        rst = 1'b1; gate = 1'b0; delay = '0; din = '0;
        model_reset();

        // reset state: passthrough, valid, not clamped
        cyc(1'b1, 1'b0, 3'd3, 32'h0abc_1234);
        cyc(1'b1, 1'b1, 3'd3, 32'h1234_5678);
        #2;
        check("rst_pass", dout, 32'h1234_5678);
        check("rst_valid", 32'(valid), 32'd1);
        check("rst_clamped", 32'(clamped), 32'd0);

        // 1: steady delay 3
        for (int n = 1; n <= 8; n++) begin
            cyc(1'b0, 1'b1, 3'd3, {16'(16'h100 + n), 16'(n)});
            #2;
            if (n <= 2) check("s1_valid_low", 32'(valid), 32'd0);
            if (n == 3) begin
                check("s1_first_out", dout, 32'h0101_0001);
                check("s1_valid_high", 32'(valid), 32'd1);
            end
            if (n == 6) check("s1_steady", dout, 32'h0104_0004);
        end

        // 2: sparse gate with delay 2
        cyc(1'b0, 1'b0, 3'd2, 32'h0);
        #2;
        check("s2_valid_after_change", 32'(valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b1, 3'd2, {16'(16'h100 + 10*(k+1)), 16'(10*(k+1))});
            #2;
            if (k == 0) check("s2_valid_g1", 32'(valid), 32'd0);
            if (k == 1) begin
                check("s2_out_g2", 32'(dout[15:0]), 32'd10);
                check("s2_valid_g2", 32'(valid), 32'd1);
            end
            if (k == 2) check("s2_out_g3", 32'(dout[15:0]), 32'd20);
            cyc(1'b0, 1'b0, 3'd2, $urandom);
            cyc(1'b0, 1'b0, 3'd2, $urandom);
            #2;
            if (k == 2) check("s2_hold", 32'(dout[15:0]), 32'd20);
        end

        // 3: passthrough
        cyc(1'b0, 1'b0, 3'd0, 32'h3333_0000);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'(i % 2), 3'd0, $urandom);
            #2;
            din = $urandom;
            #1;
            check("s3_pass", dout, din);
            check("s3_valid", 32'(valid), 32'd1);
        end

        // 4: clamp 7 -> 4
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 3'd7, 32'hC000_0000 + i);
            #2;
            if (i == 0) begin
                check("s4_clamped", 32'(clamped), 32'd1);
                check("s4_valid_low", 32'(valid), 32'd0);
            end
        end
        check("s4_out", dout, 32'hC000_0000);
        cyc(1'b0, 1'b1, 3'd4, 32'hC000_0004);
        #2;
        check("s4_unclamped", 32'(clamped), 32'd0);
        check("s4_fill_kept", 32'(valid), 32'd1);
        check("s4_out2", dout, 32'hC000_0001);

        // 5: mid-stream change 3 -> 2
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 3'd3, 32'h5000_0000 + i);
        cyc(1'b0, 1'b1, 3'd2, 32'h5000_0004);
        #2;
        check("s5_valid_low", 32'(valid), 32'd0);
        check("s5_history", dout, 32'h5000_0003);
        cyc(1'b0, 1'b1, 3'd2, 32'h5000_0005);
        #2;
        check("s5_valid_back", 32'(valid), 32'd1);
        check("s5_out", dout, 32'h5000_0004);

        // 6: asynchronous reset mid-stream
        cyc(1'b0, 1'b1, 3'd7, 32'h6000_0000);
        cyc(1'b0, 1'b1, 3'd7, 32'h6000_0001);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("s6_pass", dout, 32'h6000_0001);
        check("s6_valid", 32'(valid), 32'd1);
        check("s6_clamped", 32'(clamped), 32'd0);
        cyc(1'b1, 1'b1, 3'd3, 32'h7000_0000);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 3'd3, 32'h7000_0001 + i);
            #2;
            if (i < 2) begin
                check("s6_flushed", dout, 32'h0);
                check("s6_valid_low", 32'(valid), 32'd0);
            end
            if (i == 2) check("s6_first", dout, 32'h7000_0001);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
